// File: rtl/digitalclock_key_pkg.sv
// Shared types and timing defaults for the push-button conditioner.
package digitalclock_key_pkg;

  localparam int unsigned CNT_W           = 10;
  localparam int unsigned DEF_DEBOUNCE_MS = 20;
  localparam int unsigned DEF_LONG_MS     = 800;
  localparam int unsigned DEF_REPEAT_MS   = 200;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    StReleased,
    StPressDb,
    StHeld,
    StLong,
    StReleaseDb
  } key_state_e;

  // True on the tick that brings the counter up to limit.
  function automatic logic tick_hit(input logic tick, input logic [CNT_W-1:0] cnt,
                                    input int unsigned limit);
    return tick && (cnt == CNT_W'(limit - 1));
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, debounce/long-press FSM and a saturating tick counter.
module key_channel
  import digitalclock_key_pkg::*;
#(
  parameter int unsigned DebounceMs = DEF_DEBOUNCE_MS,
  parameter int unsigned LongMs     = DEF_LONG_MS,
  parameter int unsigned RepeatMs   = DEF_REPEAT_MS
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic key_ni,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  logic             sync1_q, sync2_q;
  logic             raw_s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             from_long_q, from_long_d;
  logic             level_q, level_d;
  logic             long_q, long_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  assign raw_s = ~sync2_q;

  always_comb begin
    state_d     = state_q;
    from_long_d = from_long_q;
    level_d     = level_q;
    long_d      = long_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    repeat_d    = 1'b0;
    if (tick_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Every transition clears the counter, so a tick in that cycle is absorbed.
    case (state_q)
      StReleased: begin
        cnt_d = '0;
        if (raw_s) state_d = StPressDb;
      end
      StPressDb: begin
        if (!raw_s) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else if (tick_hit(tick_i, cnt_q, DebounceMs)) begin
          state_d = StHeld;
          press_d = 1'b1;
          level_d = 1'b1;
          cnt_d   = '0;
        end
      end
      StHeld: begin
        if (!raw_s) begin
          state_d     = StReleaseDb;
          from_long_d = 1'b0;
          cnt_d       = '0;
        end else if (tick_hit(tick_i, cnt_q, LongMs)) begin
          state_d  = StLong;
          long_d   = 1'b1;
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
      StLong: begin
        if (!raw_s) begin
          state_d     = StReleaseDb;
          from_long_d = 1'b1;
          cnt_d       = '0;
        end else if (tick_hit(tick_i, cnt_q, RepeatMs)) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
      StReleaseDb: begin
        if (raw_s) begin
          state_d = from_long_q ? StLong : StHeld;
          cnt_d   = '0;
        end else if (tick_hit(tick_i, cnt_q, DebounceMs)) begin
          state_d   = StReleased;
          release_d = 1'b1;
          level_d   = 1'b0;
          long_d    = 1'b0;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= StReleased;
      cnt_q       <= '0;
      from_long_q <= 1'b0;
      level_q     <= 1'b0;
      long_q      <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync1_q     <= key_ni;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      from_long_q <= from_long_d;
      level_q     <= level_d;
      long_q      <= long_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/digitalclock_key_conditioner.sv
// Turns raw active-low buttons into press/release/long/repeat events, one channel per key.
module digitalclock_key_conditioner
  import digitalclock_key_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = 2,
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int unsigned LONG_MS     = DEF_LONG_MS,
  parameter int unsigned REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic                clk,
  input  logic                rst_N,
  input  logic                tick_1ms,
  input  logic [NUM_KEYS-1:0] key_N,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DebounceMs(DEBOUNCE_MS),
      .LongMs    (LONG_MS),
      .RepeatMs  (REPEAT_MS)
    ) u_key_channel (
      .clk_i    (clk),
      .rst_ni   (rst_N),
      .tick_i   (tick_1ms),
      .key_ni   (key_N[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .long_o   (key_long[i]),
      .repeat_o (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_digitalclock_key_conditioner.sv
// Bench: reference model of the key rules plus table-driven phases and random key activity.
module tb_digitalclock_key_conditioner;

  localparam int NK  = 2;
  localparam int DEB = 20;
  localparam int LNG = 800;
  localparam int REP = 200;
  localparam int TP  = 4;

  logic          clk = 1'b0;
  logic          rst_N = 1'b0;
  logic          tick_1ms = 1'b0;
  logic [NK-1:0] key_N = '1;
  logic [NK-1:0] key_level, key_press, key_release, key_long, key_repeat;

  digitalclock_key_conditioner #(
    .NUM_KEYS   (NK),
    .DEBOUNCE_MS(DEB),
    .LONG_MS    (LNG),
    .REPEAT_MS  (REP)
  ) dut (
    .clk        (clk),
    .rst_N      (rst_N),
    .tick_1ms   (tick_1ms),
    .key_N      (key_N),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_ph  = 0;
  bit tick_always = 1'b0;

  // Model: a key's accepted level follows the synchronized input once it has
  // disagreed for DEB ticks; while accepted-pressed, held ticks drive long/repeat.
  logic [NK-1:0] m_s1, m_s2, m_lvl, m_lng, m_dis, m_press, m_rel, m_rep;
  int            m_dt[NK];
  int            m_ht[NK];

  int press_cnt[NK], rel_cnt[NK], rep_cnt[NK], long_rise[NK];
  bit rel_long_ok[NK];
  logic [NK-1:0] prev_long = '0;
  int rep_q1[$];

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endfunction

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_lvl = '0; m_lng = '0; m_dis = '0;
    m_press = '0; m_rel = '0; m_rep = '0;
    for (int k = 0; k < NK; k++) begin
      m_dt[k] = 0;
      m_ht[k] = 0;
    end
  endtask

  task automatic model_step();
    logic raw;
    if (!rst_N) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NK; k++) begin
      m_press[k] = 1'b0; m_rel[k] = 1'b0; m_rep[k] = 1'b0;
      raw = ~m_s2[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = key_N[k];
      if (raw != m_lvl[k]) begin
        if (!m_dis[k]) begin
          m_dis[k] = 1'b1;
          m_dt[k]  = 0;
        end else if (tick_1ms) begin
          if (m_dt[k] + 1 == DEB) begin
            m_lvl[k] = raw;
            m_dis[k] = 1'b0;
            m_ht[k]  = 0;
            if (raw) m_press[k] = 1'b1;
            else begin
              m_rel[k] = 1'b1;
              m_lng[k] = 1'b0;
            end
          end else m_dt[k]++;
        end
      end else if (m_dis[k]) begin
        m_dis[k] = 1'b0;
        m_ht[k]  = 0;
      end else if (m_lvl[k] && tick_1ms) begin
        m_ht[k]++;
        if (!m_lng[k] && m_ht[k] == LNG) begin
          m_lng[k] = 1'b1; m_rep[k] = 1'b1; m_ht[k] = 0;
        end else if (m_lng[k] && m_ht[k] == REP) begin
          m_rep[k] = 1'b1; m_ht[k] = 0;
        end
      end
    end
  endtask

  // One clock: model at the edge, compare at the falling edge, then set up the next tick.
  task automatic tick_cycle();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check("outputs", 32'({key_level, key_press, key_release, key_long, key_repeat}),
          32'({m_lvl, m_press, m_rel, m_lng, m_rep}));
    for (int k = 0; k < NK; k++) begin
      if (key_press[k]) press_cnt[k]++;
      if (key_release[k]) begin
        rel_cnt[k]++;
        rel_long_ok[k] = prev_long[k] && !key_long[k];
      end
      if (key_repeat[k]) begin
        rep_cnt[k]++;
        if (k == 1) rep_q1.push_back(cyc);
      end
      if (key_long[k] && !prev_long[k]) long_rise[k] = cyc;
    end
    prev_long = key_long;
    if (tick_always) tick_1ms = 1'b1;
    else begin
      tick_1ms = (tick_ph == TP - 1);
      tick_ph  = (tick_ph + 1) % TP;
    end
  endtask

  task automatic run_ticks(input int n);
    repeat (n * TP) tick_cycle();
  endtask

  typedef struct {
    logic [NK-1:0] key_n;
    int            ticks;
    int            press;
    int            rel;
    int            rep;
    logic          level_end;
    logic          long_end;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int b_press[NK], b_rel[NK], b_rep[NK];
    int start, lat, q0, dur;
    vecs[0] = '{2'b11,  30, 0, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{2'b10,  19, 0, 0, 0, 1'b0, 1'b0};  // bounce: one tick short
    vecs[2] = '{2'b11,   1, 0, 0, 0, 1'b0, 1'b0};
    vecs[3] = '{2'b10,  60, 1, 0, 0, 1'b1, 1'b0};
    vecs[4] = '{2'b11,  30, 0, 1, 0, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 900, 1, 0, 1, 1'b1, 1'b1};
    vecs[6] = '{2'b11,  10, 0, 0, 0, 1'b1, 1'b1};  // glitch inside LONG
    vecs[7] = '{2'b10, 450, 0, 0, 2, 1'b1, 1'b1};
    vecs[8] = '{2'b11,  40, 0, 1, 0, 1'b0, 1'b0};
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0; rel_cnt[k] = 0; rep_cnt[k] = 0; long_rise[k] = -1;
      rel_long_ok[k] = 1'b0;
    end
    model_reset();

    // Both keys held through reset.
    key_N = 2'b00;
    repeat (5) tick_cycle();
    check("reset_outputs", 32'({key_level, key_press, key_release, key_long, key_repeat}), 0);
    rst_N = 1'b1;
    start = cyc;
    lat = -1;
    repeat (120) begin
      tick_cycle();
      if (key_press == 2'b11 && lat < 0) lat = cyc - start;
    end
    check("reset_press_count0", press_cnt[0], 1);
    check("reset_press_count1", press_cnt[1], 1);
    check("reset_press_latency", (lat >= 80 && lat <= 87), 1);
    key_N = 2'b11;
    run_ticks(40);

    foreach (vecs[i]) begin
      b_press[0] = press_cnt[0]; b_rel[0] = rel_cnt[0]; b_rep[0] = rep_cnt[0];
      key_N = vecs[i].key_n;
      run_ticks(vecs[i].ticks);
      check($sformatf("vec%0d_press", i), press_cnt[0] - b_press[0], vecs[i].press);
      check($sformatf("vec%0d_release", i), rel_cnt[0] - b_rel[0], vecs[i].rel);
      check($sformatf("vec%0d_repeat", i), rep_cnt[0] - b_rep[0], vecs[i].rep);
      check($sformatf("vec%0d_level", i), key_level[0], vecs[i].level_end);
      check($sformatf("vec%0d_long", i), key_long[0], vecs[i].long_end);
    end

    // Long press on key1.
    q0 = rep_q1.size();
    b_rel[1] = rel_cnt[1];
    key_N = 2'b01;
    start = cyc;
    run_ticks(1500);
    check("long_rise_time", (long_rise[1] - start >= 3278 && long_rise[1] - start <= 3290), 1);
    check("long_repeat_count", rep_q1.size() - q0, 4);
    if (rep_q1.size() - q0 == 4) begin
      check("long_first_repeat", rep_q1[q0], long_rise[1]);
      for (int j = 1; j < 4; j++)
        check($sformatf("long_repeat_gap%0d", j), rep_q1[q0+j] - rep_q1[q0+j-1], REP * TP);
    end
    key_N = 2'b11;
    run_ticks(30);
    check("long_release_count", rel_cnt[1] - b_rel[1], 1);
    check("long_clears_with_release", rel_long_ok[1], 1);

    // Async reset in the middle of a long press on key0.
    key_N = 2'b10;
    run_ticks(850);
    check("pre_reset_long", key_long[0], 1);
    #2 rst_N = 1'b0;
    model_reset();
    #1 check("async_reset_outputs",
             32'({key_level, key_press, key_release, key_long, key_repeat}), 0);
    repeat (3) tick_cycle();
    rst_N = 1'b1;
    b_press[0] = press_cnt[0]; b_rel[0] = rel_cnt[0];
    run_ticks(60);
    check("post_reset_press", press_cnt[0] - b_press[0], 1);
    check("post_reset_release", rel_cnt[0] - b_rel[0], 0);
    check("post_reset_level", key_level[0], 1);
    key_N = 2'b11;
    run_ticks(30);

    // Tick held high: counters count clocks.
    tick_always = 1'b1;
    repeat (20) begin
      key_N = 2'($urandom);
      dur = ($urandom_range(0, 4) == 0) ? $urandom_range(850, 1100) : $urandom_range(1, 60);
      repeat (dur) tick_cycle();
    end
    tick_always = 1'b0;

    // Random key activity against the model.
    repeat (100) begin
      key_N = 2'($urandom);
      case ($urandom_range(0, 9))
        0:       dur = $urandom_range(250, 900) * TP;
        1, 2, 3: dur = $urandom_range(1, 6);
        default: dur = $urandom_range(1, 40) * TP;
      endcase
      repeat (dur) tick_cycle();
    end
    key_N = 2'b11;
    run_ticks(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
